// File: rtl/btn_cnt_ctrl.sv
// Button command controller: turns debounced up/down/clear levels into one-cycle
// counter commands with priority arbitration and hold-to-auto-repeat on up/down.
module btn_cnt_ctrl #(
  parameter int HOLD_CYC   = 50_000_000,
  parameter int REPEAT_CYC = 10_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_up,
  input  logic       key_dn,
  input  logic       key_clr,
  output logic       cnt_inc,
  output logic       cnt_dec,
  output logic       cnt_clr,
  output logic [1:0] owner,
  output logic       repeating
);

  localparam int MAX_CYC = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
  localparam int TW      = (MAX_CYC > 2) ? $clog2(MAX_CYC) : 1;
  localparam logic [TW-1:0] HOLD_END   = TW'(HOLD_CYC - 1);
  localparam logic [TW-1:0] REPEAT_END = TW'(REPEAT_CYC - 1);

  typedef enum logic [1:0] {IDLE, PRESS, REPEAT, WAIT_REL} state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic [2:0]    key_s;
  logic [2:0]    key_p;
  logic [2:0]    rise;
  logic          owner_held;
  logic          timer_done;

  // Both sample stages reset high so a key held through reset never looks like a new press.
  assign rise       = key_s & ~key_p;
  assign owner_held = (owner == 2'd1) ? key_s[0] : key_s[1];
  assign timer_done = (state == PRESS) ? (timer == HOLD_END) : (timer == REPEAT_END);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      timer     <= '0;
      key_s     <= 3'b111;
      key_p     <= 3'b111;
      cnt_inc   <= 1'b0;
      cnt_dec   <= 1'b0;
      cnt_clr   <= 1'b0;
      owner     <= 2'd0;
      repeating <= 1'b0;
    end else begin
      key_s   <= {key_clr, key_dn, key_up};
      key_p   <= key_s;
      cnt_inc <= 1'b0;
      cnt_dec <= 1'b0;
      cnt_clr <= 1'b0;

      case (state)
        IDLE: begin
          if (rise[2]) begin
            cnt_clr <= 1'b1;
            owner   <= 2'd3;
            state   <= WAIT_REL;
          end else if (rise[0]) begin
            cnt_inc <= 1'b1;
            owner   <= 2'd1;
            timer   <= '0;
            state   <= PRESS;
          end else if (rise[1]) begin
            cnt_dec <= 1'b1;
            owner   <= 2'd2;
            timer   <= '0;
            state   <= PRESS;
          end
        end

        // Clear preempts everything, including a release or a repeat due this cycle.
        PRESS, REPEAT: begin
          if (rise[2]) begin
            cnt_clr   <= 1'b1;
            owner     <= 2'd3;
            repeating <= 1'b0;
            timer     <= '0;
            state     <= WAIT_REL;
          end else if (!owner_held) begin
            repeating <= 1'b0;
            timer     <= '0;
            state     <= WAIT_REL;
          end else if (timer_done) begin
            cnt_inc   <= (owner == 2'd1);
            cnt_dec   <= (owner == 2'd2);
            repeating <= 1'b1;
            timer     <= '0;
            state     <= REPEAT;
          end else begin
            timer <= timer + TW'(1);
          end
        end

        WAIT_REL: begin
          if (key_s == 3'b000) begin
            owner <= 2'd0;
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
